// File: rtl/data_memory_sized_pkg.sv
// Shared encodings for the sized data memory: access sizes, controller states
// and the alignment rule used by both the store and load paths.
// Pure declarations, no logic state.
package mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // A request is rejected when its size is reserved or its byte offset does
  // not match the natural alignment of the access.
  function automatic logic size_error(input logic [1:0] size, input logic [1:0] offset);
    logic err;
    case (size)
      MEM_SIZE_BYTE: err = 1'b0;
      MEM_SIZE_HALF: err = offset[0];
      MEM_SIZE_WORD: err = (offset != 2'b00);
      default:       err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the memory stage and the data memory.
// The pipeline side uses the master modport, the memory the slave modport.
// Requests follow valid/ready; responses are single-cycle pulses.
interface data_memory_sized_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, write_data,
    input  req_ready, resp_valid, read_data, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, write_data,
    output req_ready, resp_valid, read_data, resp_error
  );

endinterface

// File: rtl/data_memory_sized_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a raw 32-bit word
// and sign- or zero-extends it. Purely combinational, no backpressure.
// Kept separate so a future cache can reuse the same extraction.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian: offset 0 is bits [7:0], halfwords sit on 2-byte boundaries.
  assign byte_shift = word_i >> {offset_i, 3'b000};
  assign half_shift = word_i >> {offset_i[1], 4'b0000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = half_shift[15:0];

  // Extend the selected lanes; reserved size yields zero (it is an error anyway).
  always_comb begin
    data_o = '0;
    case (size_i)
      MEM_SIZE_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      MEM_SIZE_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      MEM_SIZE_WORD: data_o = word_i;
      default:       data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory with sized, extended loads.
// Load latency 1 cycle (registered response), full throughput when ready.
// req_ready is low while the post-reset clear sweep runs; no other stalls.
module data_memory_sized
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_sized_if.slave   bus
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int IDXW  = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] clear_idx_q, clear_idx_d;
  logic            ready;

  // Storage: one array per byte lane so a word clear or any store is a single
  // write per lane. No reset here; the clear sweep initialises it.
  logic [7:0] mem_q [4][WORDS];

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [1:0]            offset;
  logic [IDXW-1:0]       word_idx;
  logic                  unused_addr_hi;

  logic        accept;
  logic        req_err;
  logic        store_ok;
  logic [3:0]  lane_we;
  logic [7:0]  lane_wdat [4];
  logic [1:0]  lane_rel [4];
  logic [IDXW-1:0] wr_idx;

  logic [31:0] raw_word;
  logic [31:0] load_val;

  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] read_data_q, read_data_d;

  // Address wraps modulo the memory depth; upper bits are deliberately ignored.
  assign eff_addr       = bus.address[ADDR_WIDTH-1:0];
  assign offset         = eff_addr[1:0];
  assign unused_addr_hi = ^bus.address[31:ADDR_WIDTH];

  if (ADDR_WIDTH > 2) begin : g_word_idx
    assign word_idx = eff_addr[ADDR_WIDTH-1:2];
  end else begin : g_word_idx_single
    assign word_idx = '0;
  end

  // Controller state register: reset always restarts the clear sweep at word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  // Next state: sweep every word once, then accept requests indefinitely.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    ready       = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_idx_d = clear_idx_q + 1'b1;
        if (clear_idx_q == LAST_IDX) begin
          state_d = READY;
        end
      end
      READY: ready = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  // A request in a reset cycle is dropped so nothing leaks past the restart.
  assign accept   = bus.req_valid & ready & ~reset;
  assign req_err  = size_error(bus.req_size, offset);
  assign store_ok = accept & bus.req_write & ~req_err;
  assign wr_idx   = (state_q == CLEAR) ? clear_idx_q : word_idx;

  // Lane write enables: clearing hits all lanes with zero; a store hits only
  // the lanes covered by its size, taking bytes of write_data in lane order.
  always_comb begin
    lane_we = '0;
    for (int l = 0; l < 4; l++) begin
      lane_wdat[l] = '0;
      lane_rel[l]  = 2'(l) - offset;
      if (state_q == CLEAR && !reset) begin
        lane_we[l] = 1'b1;
      end else if (store_ok) begin
        case (bus.req_size)
          MEM_SIZE_BYTE: lane_we[l] = (lane_rel[l] == 2'd0);
          MEM_SIZE_HALF: lane_we[l] = ~lane_rel[l][1];
          MEM_SIZE_WORD: lane_we[l] = 1'b1;
          default:       lane_we[l] = 1'b0;
        endcase
        lane_wdat[l] = 8'(bus.write_data >> {lane_rel[l], 3'b000});
      end
    end
  end

  // Byte-lane array writes.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we[l]) begin
        mem_q[l][wr_idx] <= lane_wdat[l];
      end
    end
  end

  assign raw_word = {mem_q[3][word_idx], mem_q[2][word_idx],
                     mem_q[1][word_idx], mem_q[0][word_idx]};

  mem_load_align u_align (
    .word_i     (raw_word),
    .offset_i   (offset),
    .size_i     (bus.req_size),
    .unsigned_i (bus.req_unsigned),
    .data_o     (load_val)
  );

  // Response next-state: loads and rejected requests respond; good stores are
  // silent and leave read_data holding the previous response.
  always_comb begin
    resp_valid_d = accept & (~bus.req_write | req_err);
    resp_error_d = resp_error_q;
    read_data_d  = read_data_q;
    if (accept && req_err) begin
      resp_error_d = 1'b1;
      read_data_d  = '0;
    end else if (accept && !bus.req_write) begin
      resp_error_d = 1'b0;
      read_data_d  = load_val;
    end
  end

  // Response registers: reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      read_data_q  <= read_data_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.read_data  = read_data_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: directed scenarios with literal expectations,
// then randomized traffic, all checked against a byte-array reference model.
module tb_data_memory_sized;
  import mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int CLEAR_CYCLES = DEPTH / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_sized_if bus ();

  data_memory_sized #(.ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  bit started = 1'b0;

  // Reference model state
  logic [7:0]  model_mem [DEPTH];
  int          clr_cnt = 0;
  logic        exp_vld = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_load(input int a, input int nb, input logic uns);
    longint v = 0;
    longint full = longint'(1) << (8 * nb);
    for (int i = 0; i < nb; i++) v = v + (longint'(model_mem[(a + i) % DEPTH]) << (8 * i));
    if (!uns && nb < 4 && v >= full / 2) v = v - full;
    return 32'(v);
  endfunction

  // Model: memory is all-zero once the clear has run; requests count only
  // after CLEAR_CYCLES non-reset clocks since the last reset.
  always @(posedge clk) begin
    if (rst) begin
      clr_cnt  = 0;
      exp_vld  = 1'b0;
      exp_err  = 1'b0;
      exp_data = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    end else begin
      exp_vld = 1'b0;
      if (clr_cnt >= CLEAR_CYCLES && bus.req_valid) begin
        int a;
        int nb;
        a  = int'(bus.address[7:0]);
        nb = 1 << bus.req_size;
        if (bus.req_size == MEM_SIZE_RSVD || (a % nb) != 0) begin
          exp_vld  = 1'b1;
          exp_err  = 1'b1;
          exp_data = '0;
        end else if (bus.req_write) begin
          for (int i = 0; i < nb; i++)
            model_mem[(a + i) % DEPTH] = 8'((bus.write_data >> (8 * i)) & 32'hFF);
        end else begin
          exp_vld  = 1'b1;
          exp_err  = 1'b0;
          exp_data = model_load(a, nb, bus.req_unsigned);
        end
      end
      if (clr_cnt < CLEAR_CYCLES) clr_cnt++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 32'(bus.req_ready), 32'(clr_cnt >= CLEAR_CYCLES));
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_vld));
      chk("read_data", bus.read_data, exp_data);
      if (exp_vld) chk("resp_error", 32'(bus.resp_error), 32'(exp_err));
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.address      = addr;
    bus.write_data   = wd;
  endtask

  // One request: wait (bounded) for ready, present it for one edge, return at
  // the following negedge where the response of a load is visible.
  task automatic req(input logic w, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
    drive(w, sz, uns, addr, wd);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Counts clocks from the current negedge until req_ready rises.
  task automatic count_clear(input string name);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(CLEAR_CYCLES));
  endtask

  initial begin
    bus.req_valid = 1'b0;
    drive(1'b0, MEM_SIZE_WORD, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_read_data", bus.read_data, 32'h0);

    // Clear latency with a load held on the bus throughout.
    rst = 1'b0;
    drive(1'b0, MEM_SIZE_WORD, 1'b0, 32'h40, 32'h0);
    bus.req_valid = 1'b1;
    count_clear("clear_cycles");
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("first_load_valid", 32'(bus.resp_valid), 32'd1);
    chk("first_load_data", bus.read_data, 32'h0);

    // Extension and lane selection.
    req(1'b1, MEM_SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    req(1'b0, MEM_SIZE_BYTE, 1'b0, 32'h11, 32'h0);
    chk("byte_signed", bus.read_data, 32'hFFFFFFBE);
    req(1'b0, MEM_SIZE_BYTE, 1'b1, 32'h11, 32'h0);
    chk("byte_unsigned", bus.read_data, 32'h000000BE);
    req(1'b0, MEM_SIZE_HALF, 1'b0, 32'h12, 32'h0);
    chk("half_signed", bus.read_data, 32'hFFFFDEAD);
    req(1'b0, MEM_SIZE_HALF, 1'b1, 32'h12, 32'h0);
    chk("half_unsigned", bus.read_data, 32'h0000DEAD);

    // Partial store only touches its lane.
    req(1'b1, MEM_SIZE_BYTE, 1'b0, 32'h13, 32'hAAAAAA7F);
    req(1'b0, MEM_SIZE_WORD, 1'b0, 32'h10, 32'h0);
    chk("byte_merge", bus.read_data, 32'h7FADBEEF);
    req(1'b0, MEM_SIZE_WORD, 1'b0, 32'h14, 32'h0);
    chk("neighbour_word", bus.read_data, 32'h0);

    // Errors.
    req(1'b1, MEM_SIZE_WORD, 1'b0, 32'h22, 32'h55555555);
    chk("store_mis_err", 32'(bus.resp_error), 32'd1);
    chk("store_mis_data", bus.read_data, 32'h0);
    req(1'b0, MEM_SIZE_WORD, 1'b0, 32'h20, 32'h0);
    chk("no_write_on_err", bus.read_data, 32'h0);
    chk("good_load_err", 32'(bus.resp_error), 32'd0);
    req(1'b0, MEM_SIZE_HALF, 1'b0, 32'h01, 32'h0);
    chk("half_mis_err", 32'(bus.resp_error), 32'd1);
    req(1'b0, MEM_SIZE_RSVD, 1'b0, 32'h00, 32'h0);
    chk("rsvd_size_err", 32'(bus.resp_error), 32'd1);

    // Back-to-back store then load through an aliased address.
    req(1'b1, MEM_SIZE_WORD, 1'b0, 32'h30, 32'h12345678);
    req(1'b0, MEM_SIZE_WORD, 1'b0, 32'h130, 32'h0);
    chk("store_load_alias", bus.read_data, 32'h12345678);

    // Reset right after a load is accepted, with another load presented.
    drive(1'b0, MEM_SIZE_WORD, 1'b0, 32'h30, 32'h0);
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("pre_reset_valid", 32'(bus.resp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_drops_resp", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    count_clear("clear_after_traffic_reset");

    // Reset during the clear sweep.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_clear("clear_after_mid_reset");
    req(1'b0, MEM_SIZE_WORD, 1'b0, 32'h30, 32'h0);
    chk("cleared_after_reset", bus.read_data, 32'h0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 47));
      drive(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Byte-addressed, little-endian data memory with byte, halfword and word accesses, load sign/zero extension, misalignment detection and a registered read port behind a valid/ready request interface. It replaces the combinational word-only data memory in the processor's memory stage and gives the pipeline a one-cycle, clocked load path. After reset, an internal state machine clears the array one word per cycle before it accepts requests.

## Interface
- ADDR_WIDTH, 8: byte-address bits decoded; depth = 2^ADDR_WIDTH bytes; must be ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  memory accepts a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 reserved (treated as error).
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- address  input  32  byte address; bits above ADDR_WIDTH-1 ignored (wrap modulo depth).
- write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse: load result or error available.
- read_data  output  32  extended load result; held until the next response.
- resp_error  output  1  qualified by resp_valid: misaligned or reserved size.
- One clock; reset is synchronous and active-high.

## Operation
- States: CLEAR, READY. reset → CLEAR with clear_idx = 0.
- CLEAR: write 32'h0 to word clear_idx (4 bytes), increment; after word 2^ADDR_WIDTH/4 − 1 → READY. req_ready = 0 throughout.
- READY: req_ready = 1; a request is accepted when req_valid && req_ready.
- Alignment: half requires address[0] = 0; word requires address[1:0] = 0. Violation or size 11 → error.
- Store accepted, no error: bytes written at the accept edge, little-endian, only the lanes of the size; other bytes untouched. No response for stores that succeed.
- Store with error: no byte written; resp_valid = 1, resp_error = 1, read_data = 0 next cycle.
- Load accepted: next cycle resp_valid = 1, read_data = extended value, resp_error = 0. Load with error: resp_error = 1, read_data = 0.
- Extension: byte → bits [31:8] = req_unsigned ? 0 : bit 7; half → bits [31:16] = req_unsigned ? 0 : bit 15; word unaffected.
- Address wrap: effective address = address[ADDR_WIDTH-1:0]; aligned accesses never straddle the top.

## Timing
- Reset values: req_ready 0, resp_valid 0, read_data 32'h0, resp_error 0, clear_idx 0.
- Clear latency: exactly 2^ADDR_WIDTH/4 cycles after reset deasserts (64 for default) before req_ready rises.
- Load latency: 1 cycle accept → resp_valid; back-to-back requests every cycle, full throughput.
- Store-then-load, same address, consecutive cycles: load returns the new data (write precedes read at that edge).
- Array is not pre-read combinationally; read_data changes only on a response cycle or reset.
- reset asserted mid-CLEAR or mid-traffic: restart CLEAR from word 0; a pending response is dropped (resp_valid 0 next cycle).
- req_valid while req_ready = 0: ignored, no side effects; requester must hold.

## Structure
- Package mem_pkg: size encodings MEM_SIZE_BYTE/HALF/WORD/RSVD, state enum {CLEAR, READY}.
- Sub-module mem_load_align: combinational lane select plus sign/zero extension from the raw 32-bit word, offset, size and req_unsigned; reusable by a future cache.
- Storage: four byte-lane arrays of 2^ADDR_WIDTH/4 entries indexed by word address, so clearing and stores need one write per lane per cycle.

## Test plan
- Reset, hold req_valid = 1 → req_ready stays 0 for 64 cycles, then 1; word load at 0x40 returns 32'h0.
- Word store 0xDEADBEEF @0x10, byte load @0x11 signed → 32'hFFFFFFBE; unsigned → 32'h000000BE; half load @0x12 signed → 32'hFFFFDEAD.
- Byte store 0x7F @0x13 over 0xDEADBEEF → word load @0x10 returns 32'h7FADBEEF; neighbouring word @0x14 is unchanged.
- Word store @0x22 → resp_error = 1, read_data 0; word load @0x20 shows no change. Half load @0x01 and size 11 also error.
- Store 0x12345678 @0x30 then load @0x30 on the next cycle → 0x12345678 one cycle later; address 0x130 with ADDR_WIDTH = 8 aliases 0x30.
- Assert reset during cycle 20 of CLEAR and again one cycle after a load is accepted → no resp_valid, CLEAR restarts, 64 fresh cycles before req_ready.
